// File: rtl/perf_counter_mmio.sv
// Memory-mapped performance counters with tear-free 16-bit reads.
// Optional build macro PERFCNT_SATURATE_EN: counters saturate instead of wrapping.
module perf_counter_mmio #(
  parameter logic [15:0] BASE_ADDR = 16'hFFE0,
  parameter int          CNT_WIDTH = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        bpredicts_inc,
  input  logic        bmispredicts_inc,
  input  logic        stalls_inc,
  input  logic        retire_inc,
  input  logic [15:0] mem_address,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [15:0] mem_wdata,
  output logic        sel,
  output logic [15:0] mem_rdata,
  output logic        mem_resp
);

  localparam int HW = CNT_WIDTH - 16;

  typedef enum logic {S_IDLE, S_RESP} state_t;

  state_t               r_state;
  logic [CNT_WIDTH-1:0] r_cnt    [4];
  logic [HW-1:0]        r_shadow [4];
  logic [3:0]           r_ovf;
  logic [15:0]          r_rdata;
  logic                 r_resp;

  logic [3:0]  w_inc;
  logic [3:0]  w_off;
  logic [1:0]  w_idx;
  logic        w_req;
  logic        w_is_cnt;
  logic        w_hi;
  logic        w_is_stat;
  logic [3:0]  w_dec;
  logic [3:0]  w_clr;
  logic [3:0]  w_lat;
  logic [3:0]  w_max;
  logic [3:0]  w_wrap;
  logic [3:0]  w_w1c;
  logic [15:0] w_rd;
  logic        w_unused;

  assign w_inc = {retire_inc, stalls_inc,
                  bmispredicts_inc, bpredicts_inc};

  assign sel       = mem_address[15:5] == BASE_ADDR[15:5];
  assign w_off     = mem_address[4:1];
  assign w_idx     = w_off[2:1];
  assign w_hi      = w_off[0];
  assign w_is_cnt  = ~w_off[3];
  assign w_is_stat = w_off == 4'd8;
  assign w_req     = (r_state == S_IDLE) & sel
                   & (mem_read | mem_write);
  assign w_dec     = 4'b0001 << w_idx;

  assign w_clr = {4{w_req & mem_write & w_is_cnt & ~w_hi}}
               & w_dec;
  assign w_lat = {4{w_req & mem_read & w_is_cnt & ~w_hi}}
               & w_dec;
  assign w_w1c = (w_req & mem_write & w_is_stat)
               ? mem_wdata[3:0] : 4'b0000;

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      w_max[i] = &r_cnt[i];
    end
  end

  // a clear on the same edge suppresses the overflow flag
  assign w_wrap = w_inc & w_max & ~w_clr;

  always_comb begin
    w_rd = '0;
    unique case (1'b1)
      w_is_cnt & ~w_hi: w_rd = r_cnt[w_idx][15:0];
      w_is_cnt & w_hi:  w_rd[HW-1:0] = r_shadow[w_idx];
      w_is_stat:        w_rd[3:0] = r_ovf;
      default:          w_rd = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) begin
        r_cnt[i]    <= '0;
        r_shadow[i] <= '0;
      end
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (w_clr[i]) begin
          r_cnt[i]    <= '0;
          r_shadow[i] <= '0;
        end else begin
          if (w_lat[i])
            r_shadow[i] <= r_cnt[i][CNT_WIDTH-1:16];
`ifdef PERFCNT_SATURATE_EN
          if (w_inc[i] && !w_max[i])
            r_cnt[i] <= r_cnt[i] + 1'b1;
`else
          if (w_inc[i])
            r_cnt[i] <= r_cnt[i] + 1'b1;
`endif
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ovf <= '0;
    end else begin
      r_ovf <= (r_ovf & ~w_w1c) | w_wrap;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_resp  <= 1'b0;
      r_rdata <= '0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (w_req) begin
            r_state <= S_RESP;
            r_resp  <= 1'b1;
            r_rdata <= mem_read ? w_rd : 16'h0000;
          end
        end
        S_RESP: begin
          r_state <= S_IDLE;
          r_resp  <= 1'b0;
          r_rdata <= '0;
        end
        default: begin
          r_state <= S_IDLE;
          r_resp  <= 1'b0;
          r_rdata <= '0;
        end
      endcase
    end
  end

  assign mem_resp  = r_resp;
  assign mem_rdata = r_rdata;

  assign w_unused = ^{mem_address[0], mem_wdata[15:4]};

endmodule

// File: tb/tb_perf_counter_mmio.sv
// Scoreboard bench for perf_counter_mmio (17-bit counters).
// Directed MMIO traffic; a monitor pops expected read data on each mem_resp.
module tb_perf_counter_mmio;

  localparam int CW = 17;
`ifdef PERFCNT_SATURATE_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  inc;
  logic [15:0] addr;
  logic        rd;
  logic        wr;
  logic [15:0] wdata;
  logic        sel;
  logic [15:0] rdata;
  logic        resp;

  always #5 clk = ~clk;

  perf_counter_mmio #(
    .BASE_ADDR(16'hFFE0),
    .CNT_WIDTH(CW)
  ) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .bpredicts_inc    (inc[0]),
    .bmispredicts_inc (inc[1]),
    .stalls_inc       (inc[2]),
    .retire_inc       (inc[3]),
    .mem_address      (addr),
    .mem_read         (rd),
    .mem_write        (wr),
    .mem_wdata        (wdata),
    .sel              (sel),
    .mem_rdata        (rdata),
    .mem_resp         (resp)
  );

  typedef struct {
    bit          chk;
    logic [15:0] data;
    string       name;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int errors = 0;

  task automatic check16(string name, logic [15:0] act,
                         logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    if (rst_n && resp) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_resp: got resp, expected none");
      end else begin
        e = q.pop_front();
        if (e.chk) check16(e.name, rdata, e.data);
      end
    end
  end

  task automatic xfer(string name, logic [15:0] a, bit w,
                      logic [15:0] d, logic [15:0] exp,
                      bit chk, bit ret);
    exp_t e;
    e.chk  = chk;
    e.data = exp;
    e.name = name;
    q.push_back(e);
    @(negedge clk);
    addr  = a;
    wdata = d;
    rd    = !w;
    wr    = w;
    if (ret) inc[3] = 1'b1;
    @(posedge clk);
    #1;
    if (ret) inc[3] = 1'b0;
    check16({name, "_lat"}, {15'b0, resp}, 16'd1);
    @(negedge clk);
    rd = 1'b0;
    wr = 1'b0;
    @(posedge clk);
    #1;
    check16({name, "_pulse"}, {15'b0, resp}, 16'd0);
  endtask

  task automatic rdw(string n, logic [15:0] a,
                     logic [15:0] exp);
    xfer(n, a, 1'b0, 16'h0, exp, 1'b1, 1'b0);
  endtask

  task automatic wrw(string n, logic [15:0] a,
                     logic [15:0] d);
    xfer(n, a, 1'b1, d, 16'h0, 1'b0, 1'b0);
  endtask

  task automatic run(logic [3:0] m, int n);
    @(negedge clk);
    inc = inc | m;
    repeat (n) @(negedge clk);
    inc = inc & ~m;
  endtask

  initial begin
    rst_n = 1'b0;
    inc   = '0;
    addr  = 16'h0000;
    rd    = 1'b0;
    wr    = 1'b0;
    wdata = 16'h0000;
    #1;
    check16("rst_resp", {15'b0, resp}, 16'd0);
    check16("rst_rdata", rdata, 16'h0000);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // basic count and read
    run(4'b0001, 5);
    rdw("t1_lo", 16'hFFE0, 16'h0005);
    rdw("t1_hi", 16'hFFE2, 16'h0000);

    // counters 1 and 2 to 0xFFFF
    run(4'b0110, 65535);
    rdw("t2_lo", 16'hFFE8, 16'hFFFF);
    run(4'b0100, 1);
    rdw("t2_shadow", 16'hFFEA, 16'h0000);
    rdw("t2_lo2", 16'hFFE8, 16'h0000);
    rdw("t2_hi2", 16'hFFEA, 16'h0001);

    // counter 1 to all-ones, then overflow
    run(4'b0010, 65536);
    rdw("t3_stat0", 16'hFFF0, 16'h0000);
    rdw("t3_max_lo", 16'hFFE4, 16'hFFFF);
    rdw("t3_max_hi", 16'hFFE6, 16'h0001);
    run(4'b0010, 1);
    rdw("t3_ovf_lo", 16'hFFE4, SAT ? 16'hFFFF : 16'h0000);
    rdw("t3_ovf_hi", 16'hFFE6, SAT ? 16'h0001 : 16'h0000);
    rdw("t3_stat1", 16'hFFF0, 16'h0002);
    wrw("t3_w1c_miss", 16'hFFF0, 16'h0001);
    rdw("t3_stat2", 16'hFFF0, 16'h0002);
    wrw("t3_w1c", 16'hFFF0, 16'h0002);
    rdw("t3_stat3", 16'hFFF0, 16'h0000);

    // clear beats a same-edge increment
    run(4'b1000, 3);
    rdw("t4_pre", 16'hFFEC, 16'h0003);
    xfer("t4_clr", 16'hFFEC, 1'b1, 16'hABCD, 16'h0,
         1'b0, 1'b1);
    rdw("t4_lo", 16'hFFEC, 16'h0000);
    run(4'b1000, 2);
    wrw("t4_hiwr", 16'hFFEE, 16'h1234);
    rdw("t4_lo2", 16'hFFEC, 16'h0002);
    rdw("t4_hi2", 16'hFFEE, 16'h0000);
    rdw("t4_stat", 16'hFFF0, 16'h0000);

    // shadow after clear, unmapped offsets, out of window
    wrw("t5_clr1", 16'hFFE4, 16'h0000);
    rdw("t5_shadow", 16'hFFE6, 16'h0000);
    rdw("t5_unmap18", 16'hFFF8, 16'h0000);
    rdw("t5_unmap12", 16'hFFF2, 16'h0000);
    @(negedge clk);
    addr = 16'hFFE0;
    #1;
    check16("t5_sel_in", {15'b0, sel}, 16'd1);
    addr = 16'hFFDE;
    #1;
    check16("t5_sel_out", {15'b0, sel}, 16'd0);
    rd = 1'b1;
    repeat (3) begin
      @(posedge clk);
      #1;
      check16("t5_noresp", {15'b0, resp}, 16'd0);
    end
    @(negedge clk);
    rd = 1'b0;

    // reset during RESP
    @(negedge clk);
    addr = 16'hFFE0;
    rd   = 1'b1;
    @(posedge clk);
    #1;
    check16("t6_resp_pre", {15'b0, resp}, 16'd1);
    check16("t6_rdata_pre", rdata, 16'h0005);
    rst_n = 1'b0;
    #1;
    check16("t6_resp_rst", {15'b0, resp}, 16'd0);
    check16("t6_rdata_rst", rdata, 16'h0000);
    @(negedge clk);
    rd = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    rdw("t6_c0", 16'hFFE0, 16'h0000);
    rdw("t6_c2", 16'hFFE8, 16'h0000);
    rdw("t6_c3", 16'hFFEC, 16'h0000);
    rdw("t6_stat", 16'hFFF0, 16'h0000);

    repeat (3) @(negedge clk);
    check16("sb_empty", 16'(q.size()), 16'd0);
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
